// File: rtl/grid_readout_pkg.sv
// Shared constants, sizing helpers and the readout state encoding for the grid readout block.
package grid_readout_pkg;

  localparam int DEF_GRID_ORD = 3;

  // One-hot state encoding, same style as the solver FSM.
  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_WAIT_DONE = 6'b000010,
    ST_PRIME     = 6'b000100,
    ST_STREAM    = 6'b001000,
    ST_DONE_OK   = 6'b010000,
    ST_DONE_FAIL = 6'b100000
  } rd_state_e;

  function automatic int grid_len(input int ord);
    return ord * ord;
  endfunction

  function automatic int grid_area(input int ord);
    return (ord * ord) * (ord * ord);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot tile value to binary: value = lowest set bit + 1 (0 when empty); err on empty or multi-hot.
module onehot_to_bin #(
  parameter int LEN   = 9,
  parameter int VAL_W = 4
) (
  input  logic [LEN-1:0]   onehot,
  output logic [VAL_W-1:0] value,
  output logic             err
);

  localparam logic [LEN-1:0] ONE = LEN'(1);

  always_comb begin
    value = '0;
    // Descending scan so the lowest set bit wins on multi-hot input.
    for (int k = LEN - 1; k >= 0; k--) begin
      if (onehot[k]) value = VAL_W'(k + 1);
    end
    err = (onehot == '0) || ((onehot & (onehot - ONE)) != '0);
  end

endmodule

// File: rtl/grid_readout.sv
// Reads every solved tile in row-major order after the solver finishes and streams
// the binary values out on a valid/ready interface, one beat per cell.
module grid_readout
  import grid_readout_pkg::*;
#(
  parameter int GRID_ORD = DEF_GRID_ORD,
  parameter int IDX_W    = $clog2(grid_area(GRID_ORD)),
  parameter int VAL_W    = $clog2(grid_len(GRID_ORD) + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dump_req,
  input  logic                          grid_done,
  input  logic                          grid_success,
  output logic [IDX_W-1:0]              rd_idx,
  input  logic [grid_len(GRID_ORD)-1:0] rd_onehot,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_idx,
  output logic [VAL_W-1:0]              out_value,
  output logic                          out_err,
  output logic                          out_last,
  output logic                          busy,
  output logic                          rd_ok,
  output logic                          rd_fail,
  output logic                          err_seen
);

  localparam int               GRID_LEN  = grid_len(GRID_ORD);
  localparam int               GRID_AREA = grid_area(GRID_ORD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(GRID_AREA - 1);

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [VAL_W-1:0] out_value_q, out_value_d;
  logic             out_err_q, out_err_d;
  logic             out_last_q, out_last_d;
  logic             err_seen_q, err_seen_d;

  logic [VAL_W-1:0] conv_value;
  logic             conv_err;
  logic             do_load;

  onehot_to_bin #(
    .LEN   (GRID_LEN),
    .VAL_W (VAL_W)
  ) u_conv (
    .onehot (rd_onehot),
    .value  (conv_value),
    .err    (conv_err)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    err_seen_d  = err_seen_q;
    do_load     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE_OK, ST_DONE_FAIL: begin
        if (dump_req) begin
          err_seen_d = 1'b0;
          idx_d      = '0;
          if (grid_done && grid_success) state_d = ST_PRIME;
          else if (grid_done)            state_d = ST_DONE_FAIL;
          else                           state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (grid_done && grid_success) state_d = ST_PRIME;
        else if (grid_done)            state_d = ST_DONE_FAIL;
      end
      ST_PRIME: begin
        if (!grid_done) begin
          state_d = ST_DONE_FAIL;
        end else begin
          do_load = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Solver dropping done means its tile state is gone: abort ahead of any handshake.
        if (!grid_done) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE_FAIL;
        end else if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = ST_DONE_OK;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The read mux already presents cell idx_q, so the next beat loads with no bubble.
    if (do_load) begin
      out_valid_d = 1'b1;
      out_idx_d   = idx_q;
      out_value_d = conv_value;
      out_err_d   = conv_err;
      out_last_d  = (idx_q == LAST_IDX);
      err_seen_d  = err_seen_q | conv_err;
      idx_d       = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      err_seen_q  <= err_seen_d;
    end
  end

  assign rd_idx    = idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_value = out_value_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;
  assign err_seen  = err_seen_q;
  assign busy      = (state_q == ST_WAIT_DONE) || (state_q == ST_PRIME) || (state_q == ST_STREAM);
  assign rd_ok     = (state_q == ST_DONE_OK);
  assign rd_fail   = (state_q == ST_DONE_FAIL);

endmodule

// File: tb/tb_grid_readout.sv
// Randomized bench for grid_readout: a behavioural grid model supplies tile values and
// predicts every streamed beat, stall behaviour, failure/abort handling and reset.
module tb_grid_readout;

  localparam int GRID_ORD = 2;
  localparam int LEN      = GRID_ORD * GRID_ORD;
  localparam int AREA     = LEN * LEN;
  localparam int IDX_W    = $clog2(AREA);
  localparam int VAL_W    = $clog2(LEN + 1);

  logic             clk = 1'b0;
  logic             reset, dump_req, grid_done, grid_success, out_ready;
  logic [IDX_W-1:0] rd_idx, out_idx;
  logic [LEN-1:0]   rd_onehot;
  logic [VAL_W-1:0] out_value;
  logic             out_valid, out_err, out_last, busy, rd_ok, rd_fail, err_seen;

  logic [LEN-1:0]   grid [AREA];
  int               n_checks = 0;
  int               n_fail   = 0;

  assign rd_onehot = grid[rd_idx];

  always #5 clk = ~clk;

  grid_readout #(.GRID_ORD(GRID_ORD)) dut (
    .clock        (clk),
    .reset        (reset),
    .dump_req     (dump_req),
    .grid_done    (grid_done),
    .grid_success (grid_success),
    .rd_idx       (rd_idx),
    .rd_onehot    (rd_onehot),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_value    (out_value),
    .out_err      (out_err),
    .out_last     (out_last),
    .busy         (busy),
    .rd_ok        (rd_ok),
    .rd_fail      (rd_fail),
    .err_seen     (err_seen)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_val(input logic [LEN-1:0] oh);
    for (int k = 0; k < LEN; k++) if (oh[k]) return k + 1;
    return 0;
  endfunction

  function automatic bit model_err(input logic [LEN-1:0] oh);
    return $countones(oh) != 1;
  endfunction

  function automatic bit model_seen(input int upto);
    bit s = 0;
    for (int i = 0; i <= upto; i++) s |= model_err(grid[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_grid();
    for (int i = 0; i < AREA; i++) begin
      grid[i] = '0;
      grid[i][$urandom_range(LEN - 1)] = 1'b1;
    end
  endtask

  task automatic start_dump();
    out_ready = 1'b0;
    dump_req  = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("accept_busy", busy, 1);
    chk("prime_no_valid", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
  endtask

  task automatic check_all_zero();
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_value", out_value, 0);
    chk("rst_err", out_err, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_ok", rd_ok, 0);
    chk("rst_rd_fail", rd_fail, 0);
    chk("rst_err_seen", err_seen, 0);
  endtask

  // Consumes the stream from the first valid beat; optionally aborts or resets at a given beat.
  task automatic collect(input int ready_pct, input int abort_at, input int reset_at);
    int               nb = 0;
    int               cyc = 0;
    bit               stalled = 0;
    logic [IDX_W-1:0] s_idx;
    logic [VAL_W-1:0] s_val;
    logic             s_err, s_last;
    while (nb < AREA) begin
      if (cyc > 40 * AREA + 50) begin
        chk("stream_timeout", nb, AREA);
        return;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (ready_pct == 100) chk("b2b_valid", out_valid, 1);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_idx", out_idx, s_idx);
        chk("stall_value", out_value, s_val);
        chk("stall_err", out_err, s_err);
        chk("stall_last", out_last, s_last);
      end
      if (out_valid && nb == abort_at) begin
        grid_done = 1'b0;
        tick();
        chk("abort_valid", out_valid, 0);
        chk("abort_rd_fail", rd_fail, 1);
        chk("abort_busy", busy, 0);
        grid_done = 1'b1;
        return;
      end
      if (out_valid && nb == reset_at) begin
        reset = 1'b1;
        tick();
        check_all_zero();
        reset = 1'b0;
        return;
      end
      if (out_valid && out_ready) begin
        chk("beat_idx", out_idx, nb);
        chk("beat_value", out_value, model_val(grid[nb]));
        chk("beat_err", out_err, model_err(grid[nb]));
        chk("beat_last", out_last, nb == AREA - 1);
        chk("beat_err_seen", err_seen, model_seen(nb));
        nb++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        s_idx   = out_idx;
        s_val   = out_value;
        s_err   = out_err;
        s_last  = out_last;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dump_req = 1'b0; grid_done = 1'b0; grid_success = 1'b0; out_ready = 1'b0;
    fill_grid();
    tick();
    tick();
    check_all_zero();
    reset = 1'b0;
    tick();

    // Solved grid, full-rate dump.
    grid_done = 1'b1; grid_success = 1'b1;
    start_dump();
    collect(100, -1, -1);
    chk("full_rd_ok", rd_ok, 1);
    chk("full_busy", busy, 0);
    chk("full_valid_off", out_valid, 0);
    chk("full_err_seen", err_seen, 0);

    // Re-dump from DONE_OK with random back-pressure.
    fill_grid();
    start_dump();
    collect(50, -1, -1);
    chk("stall_rd_ok", rd_ok, 1);

    // Solver failed: no beats, rd_fail.
    grid_success = 1'b0;
    out_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("fail_no_valid0", out_valid, 0);
    tick();
    chk("fail_rd_fail", rd_fail, 1);
    chk("fail_busy", busy, 0);
    chk("fail_no_valid1", out_valid, 0);
    chk("fail_rd_ok", rd_ok, 0);

    // Dump requested before the solver finishes; extra request while busy is ignored.
    grid_done = 1'b0;
    out_ready = 1'b0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_no_valid", out_valid, 0);
    end
    grid_done = 1'b1; grid_success = 1'b1;
    tick();
    chk("done_prime_no_valid", out_valid, 0);
    tick();
    chk("done_first_valid", out_valid, 1);
    chk("done_first_idx", out_idx, 0);
    collect(100, -1, -1);
    chk("wait_rd_ok", rd_ok, 1);

    // Empty and multi-hot cells.
    fill_grid();
    grid[5] = '0;
    grid[9] = '0;
    grid[9][1] = 1'b1;
    grid[9][2] = 1'b1;
    start_dump();
    collect(70, -1, -1);
    chk("errgrid_err_seen", err_seen, 1);
    chk("errgrid_rd_ok", rd_ok, 1);

    // Solver drops done mid-stream, then reset during a re-dump.
    fill_grid();
    start_dump();
    collect(100, 7, -1);
    start_dump();
    collect(100, -1, 3);
    tick();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
